ctrl_dem4bit: RTL

Run controller for the 4-bit counter / two-digit 7-segment display path. It sequences counting with start/stop/load, up/down direction and one-shot or wrap modes, and paces each step with an internal prescaler. It outputs the current count together with its decimal units and tens digits, which feed the existing segment decoder directly.

---
 rtl/ctrl_dem4bit_if.sv | 27 ++
 rtl/ctrl_dem4bit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ctrl_dem4bit_if.sv
// Control and status bundle for the counter/7-segment run controller.
// All controls are level-sampled on every rising clock edge: there is no valid/ready handshake.
interface ctrl_dem4bit_if;
   logic       start;
   logic       stop;
   logic       load;
   logic [3:0] din;
   logic       up_dn;
   logic       wrap;
   logic [3:0] q;
   logic [3:0] d0;
   logic [3:0] d1;
   logic       tick;
   logic       busy;
   logic       done;
   logic [1:0] state_dbg;

   modport master (
      output start, stop, load, din, up_dn, wrap,
      input  q, d0, d1, tick, busy, done, state_dbg
   );

   modport slave (
      input  start, stop, load, din, up_dn, wrap,
      output q, d0, d1, tick, busy, done, state_dbg
   );
endinterface

// File: rtl/ctrl_dem4bit.sv
// Run controller for the 4-bit counter and its two-digit display: start/stop/load sequencing,
// up/down and wrap/one-shot stepping paced by an internal prescaler. All outputs registered.
module ctrl_dem4bit #(
   parameter int PRESCALE = 4,
   parameter int MAXV     = 15
) (
   input logic           ck,
   input logic           rs,
   ctrl_dem4bit_if.slave bus
);
   localparam int             PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PTERM = PW'(PRESCALE - 1);
   localparam logic [3:0]     MAXQ  = 4'(MAXV);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] pre, pre_n;
   logic [3:0]    q, q_n;
   logic [3:0]    d0, d0_n;
   logic [3:0]    d1, d1_n;
   logic          tick, tick_n;
   logic          done, done_n;
   logic          busy;
   logic [3:0]    din_c;

   assign din_c = (bus.din > MAXQ) ? MAXQ : bus.din;

   always_comb begin
      state_n = state;
      pre_n   = pre;
      q_n     = q;
      tick_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load) q_n = din_c;
            if (bus.start) begin
               state_n = RUN;
               pre_n   = '0;
            end
         end
         RUN: begin
            // A STOP landing on the terminal count keeps the prescaler parked at PTERM,
            // so the step it suppressed happens on the first edge after resuming.
            if (bus.stop) begin
               state_n = PAUSE;
               if (pre != PTERM) pre_n = pre + 1'b1;
            end else if (pre != PTERM) begin
               pre_n = pre + 1'b1;
            end else begin
               pre_n = '0;
               if (bus.up_dn) begin
                  if (q < MAXQ) begin
                     q_n    = q + 4'd1;
                     tick_n = 1'b1;
                  end else if (bus.wrap) begin
                     q_n    = 4'd0;
                     tick_n = 1'b1;
                  end else begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end
               end else begin
                  if (q > 4'd0) begin
                     q_n    = q - 4'd1;
                     tick_n = 1'b1;
                  end else if (bus.wrap) begin
                     q_n    = MAXQ;
                     tick_n = 1'b1;
                  end else begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end
               end
            end
         end
         PAUSE: begin
            // Prescaler holds here; STOP still held keeps the block paused.
            if (bus.load) q_n = din_c;
            if (bus.start && !bus.stop) state_n = RUN;
         end
         DONE: begin
            if (bus.load) begin
               q_n     = din_c;
               state_n = IDLE;
            end else if (bus.start) begin
               q_n     = bus.up_dn ? 4'd0 : MAXQ;
               pre_n   = '0;
               state_n = RUN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      if (q_n >= 4'd10) begin
         d1_n = 4'd1;
         d0_n = q_n - 4'd10;
      end else begin
         d1_n = 4'd0;
         d0_n = q_n;
      end
   end

   always_ff @(posedge ck or negedge rs) begin
      if (!rs) begin
         state <= IDLE;
         pre   <= '0;
         q     <= 4'd0;
         d0    <= 4'd0;
         d1    <= 4'd0;
         tick  <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         pre   <= pre_n;
         q     <= q_n;
         d0    <= d0_n;
         d1    <= d1_n;
         tick  <= tick_n;
         done  <= done_n;
         busy  <= (state_n == RUN);
      end
   end

   assign bus.q         = q;
   assign bus.d0        = d0;
   assign bus.d1        = d1;
   assign bus.tick      = tick;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.state_dbg = state;
endmodule
